// File: rtl/bench_engine_mc_pkg.sv
// Shared definitions for bench_engine_mc: FSM states, error codes,
// common opcode constants and a saturating adder.
package bench_engine_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT_OP,
    ST_NEXT_COND,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

  // Common opcode set understood by the router under test
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_RD    = 4'h1;
  localparam logic [3:0] OP_WR    = 4'h2;
  localparam logic [3:0] OP_RMW   = 4'h3;
  localparam logic [3:0] OP_BURST = 4'h4;

  // 32-bit add clamped at all-ones
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/bench_engine_mc_minsel.sv
// N-way argmin over 32-bit totals; ties resolve to the highest index.
module bench_minsel #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0][31:0] vals,
  output logic [CW-1:0]      idx,
  output logic [N-1:0]       onehot
);

  logic [31:0] best;

  // Linear scan; '<=' lets a later equal value take over the win
  always_comb begin
    idx  = '0;
    best = vals[0];
    for (int unsigned i = 1; i < N; i++) begin
      if (vals[i] <= best) begin
        best = vals[i];
        idx  = CW'(i);
      end
    end
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/bench_engine_mc.sv
// Benchmark sequencer: sweeps an op table over NUM_COND conditions against
// an external DUT via start/done, accumulating per-condition cycle totals.
// Optional macro BENCH_MAXLAT_EN adds rd_maxlat (largest single-op wait).
module bench_engine_mc
  import bench_engine_mc_pkg::*;
#(
  parameter  int NUM_COND = 4,
  parameter  int NUM_OPS  = 18,
  parameter  int REPEAT   = 1,
  parameter  int TIMEOUT  = 1024,
  localparam int CW       = $clog2(NUM_COND),
  localparam int OW       = $clog2(NUM_OPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                prog_we,
  input  logic [OW-1:0]       prog_addr,
  input  logic [3:0]          prog_op,
  input  logic [15:0]         prog_a,
  input  logic [15:0]         prog_b,
  output logic                dut_start,
  output logic [CW-1:0]       dut_cond,
  output logic [3:0]          dut_opcode,
  output logic [15:0]         dut_a,
  output logic [15:0]         dut_b,
  input  logic                dut_done,
  input  logic [CW-1:0]       rd_idx,
  output logic [31:0]         rd_cycles,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [CW-1:0]       winner_code,
  output logic [NUM_COND-1:0] winner_onehot,
  output logic [31:0]         t_total,
  output logic [31:0]         t_runtime
`ifdef BENCH_MAXLAT_EN
  , output logic [31:0]       rd_maxlat
`endif
);

  localparam logic [OW:0]  OPS_LIM  = (OW+1)'(NUM_OPS);
  localparam logic [CW:0]  COND_LIM = (CW+1)'(NUM_COND);
  localparam logic [31:0]  TO_LIM   = 32'(TIMEOUT);
  localparam logic [31:0]  PASS_MAX = 32'(REPEAT - 1);
  localparam logic [OW-1:0] OP_MAX  = OW'(NUM_OPS - 1);
  localparam logic [CW-1:0] CND_MAX = CW'(NUM_COND - 1);

  state_t state, state_nxt;

  logic [3:0]  tbl_op [NUM_OPS];
  logic [15:0] tbl_a  [NUM_OPS];
  logic [15:0] tbl_b  [NUM_OPS];

  logic [NUM_COND-1:0][31:0] total;
  logic [CW-1:0] cond;
  logic [OW-1:0] op;
  logic [31:0]   pass;
  logic [31:0]   acc;
  logic [31:0]   wcnt;
  logic [31:0]   rt;
  logic [31:0]   sum_total;
  logic [CW-1:0]       ms_idx;
  logic [NUM_COND-1:0] ms_onehot;

  logic busy_st, accept, last_op, last_pass, last_cond, timeout_hit;

  assign busy_st     = (state != ST_IDLE) && (state != ST_DONE);
  assign accept      = !busy_st && start;
  assign last_op     = (op == OP_MAX);
  assign last_pass   = (pass == PASS_MAX);
  assign last_cond   = (cond == CND_MAX);
  assign timeout_hit = ((wcnt + 32'd1) >= TO_LIM);
  assign busy        = busy_st;

  bench_minsel #(.N(NUM_COND)) u_minsel (
    .vals   (total),
    .idx    (ms_idx),
    .onehot (ms_onehot)
  );

  // Saturating sum of all condition totals
  always_comb begin
    sum_total = '0;
    for (int unsigned i = 0; i < NUM_COND; i++) sum_total = sat_add(sum_total, total[i]);
  end

  // Combinational total readout
  always_comb begin
    rd_cycles = '0;
    if ({1'b0, rd_idx} < COND_LIM) rd_cycles = total[rd_idx];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides any busy-state transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
      ST_LOAD:          state_nxt = ST_ISSUE;
      ST_ISSUE:         state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (dut_done)         state_nxt = ST_NEXT_OP;
        else if (timeout_hit) state_nxt = ST_DONE;
      end
      ST_NEXT_OP:   state_nxt = (last_op && last_pass) ? ST_NEXT_COND : ST_LOAD;
      ST_NEXT_COND: state_nxt = last_cond ? ST_DONE : ST_LOAD;
      default:      state_nxt = ST_IDLE;
    endcase
    if (busy_st && abort) state_nxt = ST_DONE;
  end

  // Datapath: table, DUT drive, accumulation and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_start     <= 1'b0;
      dut_cond      <= '0;
      dut_opcode    <= '0;
      dut_a         <= '0;
      dut_b         <= '0;
      done          <= 1'b0;
      err_code      <= ERR_OK;
      winner_code   <= '0;
      winner_onehot <= '0;
      t_total       <= '0;
      t_runtime     <= '0;
      total         <= '0;
      acc           <= '0;
      wcnt          <= '0;
      rt            <= '0;
      cond          <= '0;
      op            <= '0;
      pass          <= '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
        tbl_op[i] <= '0;
        tbl_a[i]  <= '0;
        tbl_b[i]  <= '0;
      end
    end else begin
      dut_start <= (state == ST_ISSUE) && !abort;
      if (!busy_st && prog_we && ({1'b0, prog_addr} < OPS_LIM)) begin
        tbl_op[prog_addr] <= prog_op;
        tbl_a[prog_addr]  <= prog_a;
        tbl_b[prog_addr]  <= prog_b;
      end
      if (busy_st) rt <= sat_add(rt, 32'd1);
      // t_runtime counts through the first DONE cycle, hence rt + 2
      if (busy_st && abort) begin
        err_code  <= ERR_ABORT;
        done      <= 1'b1;
        t_total   <= sum_total;
        t_runtime <= sat_add(rt, 32'd2);
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (accept) begin
              total         <= '0;
              err_code      <= ERR_OK;
              done          <= 1'b0;
              winner_code   <= '0;
              winner_onehot <= '0;
              t_total       <= '0;
              t_runtime     <= '0;
              cond          <= '0;
              op            <= '0;
              pass          <= '0;
              acc           <= '0;
              rt            <= 32'd1;
            end
          end
          ST_LOAD: begin
            dut_opcode <= tbl_op[op];
            dut_a      <= tbl_a[op];
            dut_b      <= tbl_b[op];
            dut_cond   <= cond;
          end
          ST_ISSUE: wcnt <= '0;
          ST_WAIT: begin
            acc  <= sat_add(acc, 32'd1);
            wcnt <= wcnt + 32'd1;
            if (!dut_done && timeout_hit) begin
              err_code  <= ERR_TIMEOUT;
              done      <= 1'b1;
              t_total   <= sum_total;
              t_runtime <= sat_add(rt, 32'd2);
            end
          end
          ST_NEXT_OP: begin
            if (!last_op) begin
              op <= op + OW'(1);
            end else if (!last_pass) begin
              op   <= '0;
              pass <= pass + 32'd1;
            end else begin
              total[cond] <= acc;
            end
          end
          ST_NEXT_COND: begin
            if (!last_cond) begin
              cond <= cond + CW'(1);
              op   <= '0;
              pass <= '0;
              acc  <= '0;
            end else begin
              winner_code   <= ms_idx;
              winner_onehot <= ms_onehot;
              t_total       <= sum_total;
              t_runtime     <= sat_add(rt, 32'd2);
              done          <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BENCH_MAXLAT_EN
  logic [NUM_COND-1:0][31:0] maxlat;

  // Per-condition worst single-op wait, captured once the op has completed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maxlat <= '0;
    end else if (accept) begin
      maxlat <= '0;
    end else if (state == ST_NEXT_OP && !abort && wcnt > maxlat[cond]) begin
      maxlat[cond] <= wcnt;
    end
  end

  // Combinational max-latency readout
  always_comb begin
    rd_maxlat = '0;
    if ({1'b0, rd_idx} < COND_LIM) rd_maxlat = maxlat[rd_idx];
  end
`endif

endmodule
